// File: rtl/dds_wave_gen.sv
// dds_wave_gen: direct digital synthesis waveform generator.
// A phase accumulator is followed by a three-stage pipeline: phase sampling,
// waveform shaping (sine, square, triangle, sawtooth) and amplitude scaling.
// PHASE_W must be at least 9 so the top byte of the accumulator has a carry
// bit above it.
module dds_wave_gen #(
    parameter int                 PHASE_W = 32,
    parameter logic [PHASE_W-1:0] FTW_RST = PHASE_W'(42950)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PHASE_W-1:0] ftw,
    input  logic               ftw_load,
    input  logic               phase_clr,
    input  logic [1:0]         wave_sel,
    input  logic [7:0]         amp,
    output logic [7:0]         dout,
    output logic               dout_valid,
    output logic               cycle_start
);

    // Quarter-wave sine table: round(127*sin(pi/2*(q+0.5)/64)), constant logic.
    function automatic logic [6:0] sine_quarter(input logic [5:0] q);
        logic [6:0] v;
        v = 7'd0;
        case (q)
            6'd0:  v = 7'd2;    6'd1:  v = 7'd5;    6'd2:  v = 7'd8;    6'd3:  v = 7'd11;
            6'd4:  v = 7'd14;   6'd5:  v = 7'd17;   6'd6:  v = 7'd20;   6'd7:  v = 7'd23;
            6'd8:  v = 7'd26;   6'd9:  v = 7'd29;   6'd10: v = 7'd32;   6'd11: v = 7'd35;
            6'd12: v = 7'd38;   6'd13: v = 7'd41;   6'd14: v = 7'd44;   6'd15: v = 7'd47;
            6'd16: v = 7'd50;   6'd17: v = 7'd53;   6'd18: v = 7'd56;   6'd19: v = 7'd58;
            6'd20: v = 7'd61;   6'd21: v = 7'd64;   6'd22: v = 7'd67;   6'd23: v = 7'd69;
            6'd24: v = 7'd72;   6'd25: v = 7'd74;   6'd26: v = 7'd77;   6'd27: v = 7'd79;
            6'd28: v = 7'd82;   6'd29: v = 7'd84;   6'd30: v = 7'd86;   6'd31: v = 7'd89;
            6'd32: v = 7'd91;   6'd33: v = 7'd93;   6'd34: v = 7'd95;   6'd35: v = 7'd97;
            6'd36: v = 7'd99;   6'd37: v = 7'd101;  6'd38: v = 7'd103;  6'd39: v = 7'd105;
            6'd40: v = 7'd106;  6'd41: v = 7'd108;  6'd42: v = 7'd110;  6'd43: v = 7'd111;
            6'd44: v = 7'd113;  6'd45: v = 7'd114;  6'd46: v = 7'd115;  6'd47: v = 7'd117;
            6'd48: v = 7'd118;  6'd49: v = 7'd119;  6'd50: v = 7'd120;  6'd51: v = 7'd121;
            6'd52: v = 7'd122;  6'd53: v = 7'd123;  6'd54: v = 7'd124;  6'd55: v = 7'd124;
            6'd56: v = 7'd125;  6'd57: v = 7'd125;  6'd58: v = 7'd126;  6'd59: v = 7'd126;
            6'd60: v = 7'd127;  6'd61: v = 7'd127;  6'd62: v = 7'd127;  6'd63: v = 7'd127;
            default: v = 7'd0;
        endcase
        return v;
    endfunction

    logic [PHASE_W-1:0] ftw_reg;
    logic [PHASE_W-1:0] acc;
    logic               wrap;
    logic [PHASE_W:0]   acc_sum;

    logic [7:0]         p1;
    logic [1:0]         sel1;
    logic               wrap1;
    logic               v1;

    logic [7:0]         w2;
    logic               wrap2;
    logic               v2;

    logic [5:0]         quarter_idx;
    logic [6:0]         lut_val;
    logic [7:0]         w_next;
    logic [8:0]         amp_plus1;
    logic [16:0]        product;

    // Extra top bit of the sum is the accumulator carry, i.e. the period wrap.
    assign acc_sum     = {1'b0, acc} + {1'b0, ftw_reg};
    assign quarter_idx = p1[6] ? ~p1[5:0] : p1[5:0];
    assign lut_val     = sine_quarter(quarter_idx);
    assign amp_plus1   = {1'b0, amp} + 9'd1;
    assign product     = {9'd0, w2} * {8'd0, amp_plus1};

    // Tuning word register; a newly loaded word is used from the next edge on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ftw_reg <= FTW_RST;
        end else if (ftw_load) begin
            ftw_reg <= ftw;
        end
    end

    // Phase accumulator with clear priority; wrap marks the start of a period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            wrap <= 1'b0;
        end else if (phase_clr) begin
            acc  <= '0;
            wrap <= 1'b1;
        end else if (en) begin
            acc  <= acc_sum[PHASE_W-1:0];
            wrap <= acc_sum[PHASE_W];
        end else begin
            wrap <= 1'b0;
        end
    end

    // Stage 1: capture the phase byte together with the select and flags that belong to it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1    <= 8'h00;
            sel1  <= 2'b00;
            wrap1 <= 1'b0;
            v1    <= 1'b0;
        end else begin
            p1    <= acc[PHASE_W-1 -: 8];
            sel1  <= wave_sel;
            wrap1 <= wrap;
            v1    <= en;
        end
    end

    // Waveform shaping from the stage-1 phase byte and its own select.
    always_comb begin
        w_next = p1;
        case (sel1)
            2'b00:   w_next = p1[7] ? (8'd127 - {1'b0, lut_val}) : (8'd128 + {1'b0, lut_val});
            2'b01:   w_next = p1[7] ? 8'h00 : 8'hFF;
            2'b10:   w_next = p1[7] ? ~{p1[6:0], 1'b0} : {p1[6:0], 1'b0};
            default: w_next = p1;
        endcase
    end

    // Stage 2: register the shaped waveform value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w2    <= 8'h00;
            wrap2 <= 1'b0;
            v2    <= 1'b0;
        end else begin
            w2    <= w_next;
            wrap2 <= wrap1;
            v2    <= v1;
        end
    end

    // Stage 3: scale by (amp+1)/256 and emit the sample with its flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout        <= 8'h00;
            dout_valid  <= 1'b0;
            cycle_start <= 1'b0;
        end else begin
            dout        <= 8'(product >> 8);
            dout_valid  <= v2;
            cycle_start <= wrap2 & v2;
        end
    end

endmodule
